alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 19 +
 rtl/alu_arbiter_alu_core.sv | 31 +++
 rtl/alu_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared definitions for the two-requester ALU arbiter.
//   - ALU mode encodings (2-bit)
//   - FSM state type for the arbiter controller
package alu_arbiter_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_PASS_A = 2'd0;
  localparam logic [MODE_W-1:0] MODE_PASS_B = 2'd1;
  localparam logic [MODE_W-1:0] MODE_ADD    = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SUB    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// alu_core: combinational ALU shared by both requesters.
//   a, b    : operands (WIDTH)
//   mode    : PASS_A / PASS_B / ADD / SUB
//   y       : result, modulo 2^WIDTH (carry/borrow discarded)
//   is_zero : high when y == 0
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  y,
  output logic              is_zero
);

  always_comb begin
    y = a;
    unique case (mode)
      MODE_PASS_A: y = a;
      MODE_PASS_B: y = b;
      MODE_ADD:    y = a + b;
      MODE_SUB:    y = a - b;
      default:     y = a;
    endcase
  end

  assign is_zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter in front of a single shared ALU.
//   clk, reset           : clock, async active-high reset
//   req_valid/req_ready  : per-requester handshake (bit i = requester i)
//   req{0,1}_a/_b/_mode  : operands and ALU mode per requester
//   rsp_valid/rsp_ready  : response handshake
//   rsp_id, rsp_y, rsp_zero : granted requester, result, result==0
// Optional: define ALU_ARBITER_STATS_EN to add saturating 8-bit grant
// counters grant_cnt0 / grant_cnt1.
// One operation in flight: IDLE (grant) -> EXEC (compute) -> RESP (hold).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [MODE_W-1:0] req0_mode,
  input  logic [MODE_W-1:0] req1_mode,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_y,
  output logic              rsp_zero
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  state_e            state_q, state_d;
  logic              last_q;      // requester granted most recently
  logic [WIDTH-1:0]  a_q, b_q;
  logic [MODE_W-1:0] mode_q;
  logic              id_q;
  logic [WIDTH-1:0]  y_q;
  logic              zero_q;

  logic              gnt_any;
  logic              gnt_id;
  logic [WIDTH-1:0]  alu_y;
  logic              alu_zero;

  // Grant only from IDLE; on a tie the requester not served last wins,
  // otherwise the lone requester wins. Held off while reset is asserted
  // so req_ready reads 0 during reset.
  assign gnt_any = (state_q == IDLE) && (|req_valid) && !reset;
  assign gnt_id  = (&req_valid) ? ~last_q : req_valid[1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any)   state_d = EXEC;
      EXEC:                   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = 2'b00;
    if (gnt_any) req_ready[gnt_id] = 1'b1;
    rsp_valid = (state_q == RESP);
  end

  // Request capture at the grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;   // so requester 0 wins the first tie
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_PASS_A;
      id_q   <= 1'b0;
    end else if (gnt_any) begin
      last_q <= gnt_id;
      id_q   <= gnt_id;
      a_q    <= gnt_id ? req1_a    : req0_a;
      b_q    <= gnt_id ? req1_b    : req0_b;
      mode_q <= gnt_id ? req1_mode : req0_mode;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a       (a_q),
    .b       (b_q),
    .mode    (mode_q),
    .y       (alu_y),
    .is_zero (alu_zero)
  );

  // Result registered in EXEC, held through RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q    <= '0;
      zero_q <= 1'b0;
    end else if (state_q == EXEC) begin
      y_q    <= alu_y;
      zero_q <= alu_zero;
    end
  end

  assign rsp_y    = y_q;
  assign rsp_zero = zero_q;
  assign rsp_id   = id_q;

`ifdef ALU_ARBITER_STATS_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= 8'd0;
      cnt1_q <= 8'd0;
    end else if (gnt_any) begin
      if (!gnt_id && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
      if ( gnt_id && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
